// File: rtl/stack_pkg.sv
// Command encoding for the operand stack, shared with the instruction decoder.
package stack_pkg;

    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_LOAD     = 3'd1,
        OP_PUSH     = 3'd2,
        OP_POP      = 3'd3,
        OP_POP_LOAD = 3'd4,
        OP_DUP      = 3'd5,
        OP_SWAP     = 3'd6,
        OP_CLEAR    = 3'd7
    } stack_op_t;

endpackage

// File: rtl/op_stack.sv
// Parametrised shift-register operand stack with an encoded command port,
// occupancy tracking, sticky overflow/underflow flags and an indexed peek.
// Entry 0 is the top of stack; every command takes effect on the next posedge.
module op_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1),
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  stack_op_t              op,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   err_clr,
    output logic [WIDTH-1:0]       data_out,
    output logic [WIDTH-1:0]       data_next,
    input  logic [IW-1:0]          peek_idx,
    output logic [WIDTH-1:0]       peek_data,
    output logic [CW-1:0]          count,
    output logic                   empty,
    output logic                   full,
    output logic                   ovf,
    output logic                   udf,
    output logic [WIDTH*DEPTH-1:0] data_raw
);

    logic [WIDTH-1:0] entries_q [DEPTH];
    logic [WIDTH-1:0] entries_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic is_empty, is_full, below_two;

    assign is_empty  = (count_q == '0);
    assign is_full   = (count_q == CW'(DEPTH));
    assign below_two = (count_q < CW'(2));

    // Next-state for entries, occupancy and sticky flags from the current command.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i];
        end
        count_d = count_q;
        // Clearing happens first so that an error raised in the same cycle wins.
        ovf_d   = err_clr ? 1'b0 : ovf_q;
        udf_d   = err_clr ? 1'b0 : udf_q;

        case (op)
            OP_LOAD: begin
                entries_d[0] = data_in;
                if (is_empty) begin
                    count_d = CW'(1);
                end
            end
            OP_PUSH, OP_DUP: begin
                for (int i = 1; i < DEPTH; i++) begin
                    entries_d[i] = entries_q[i-1];
                end
                entries_d[0] = (op == OP_PUSH) ? data_in : entries_q[0];
                // The bottom entry falls off on overflow; count is pinned at DEPTH.
                if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            OP_POP, OP_POP_LOAD: begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    entries_d[i] = entries_q[i+1];
                end
                entries_d[DEPTH-1] = '0;
                // POP_LOAD consumes two operands and writes the result back on top.
                if (op == OP_POP_LOAD) begin
                    entries_d[0] = data_in;
                    if (below_two) begin
                        udf_d = 1'b1;
                    end
                end else if (is_empty) begin
                    udf_d = 1'b1;
                end
                if (!is_empty) begin
                    count_d = count_q - CW'(1);
                end
            end
            OP_SWAP: begin
                entries_d[0] = entries_q[1];
                entries_d[1] = entries_q[0];
                if (below_two) begin
                    udf_d = 1'b1;
                end
            end
            OP_CLEAR: begin
                for (int i = 0; i < DEPTH; i++) begin
                    entries_d[i] = '0;
                end
                count_d = '0;
                ovf_d   = 1'b0;
                udf_d   = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // State register; reset discards all contents and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Flattened debug view of the whole stack, entry i at slice i.
    always_comb begin
        data_raw = '0;
        for (int i = 0; i < DEPTH; i++) begin
            data_raw[i*WIDTH +: WIDTH] = entries_q[i];
        end
    end

    assign data_out  = entries_q[0];
    assign data_next = entries_q[1];
    assign count     = count_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign ovf       = ovf_q;
    assign udf       = udf_q;

    // Guard covers DEPTH values that are not a power of two.
    assign peek_data = (int'(peek_idx) < DEPTH) ? entries_q[peek_idx] : '0;

endmodule

// File: tb/tb_op_stack.sv
// Directed self-checking bench for op_stack, built with DEPTH=4 so the
// overflow and peek boundaries are reachable with short sequences.
module tb_op_stack;
    import stack_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int IW    = $clog2(DEPTH);

    logic                   clk;
    logic                   rst;
    stack_op_t              op;
    logic [WIDTH-1:0]       data_in;
    logic                   err_clr;
    logic [WIDTH-1:0]       data_out;
    logic [WIDTH-1:0]       data_next;
    logic [IW-1:0]          peek_idx;
    logic [WIDTH-1:0]       peek_data;
    logic [CW-1:0]          count;
    logic                   empty;
    logic                   full;
    logic                   ovf;
    logic                   udf;
    logic [WIDTH*DEPTH-1:0] data_raw;

    int checks = 0;
    int errors = 0;

    op_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .data_in   (data_in),
        .err_clr   (err_clr),
        .data_out  (data_out),
        .data_next (data_next),
        .peek_idx  (peek_idx),
        .peek_data (peek_data),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .ovf       (ovf),
        .udf       (udf),
        .data_raw  (data_raw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one command for exactly one rising edge, then return to NOP.
    task automatic step(input stack_op_t o, input logic [WIDTH-1:0] d, input logic clr, input logic r);
        @(negedge clk);
        op      = o;
        data_in = d;
        err_clr = clr;
        rst     = r;
        @(posedge clk);
        #1;
        op      = OP_NOP;
        data_in = '0;
        err_clr = 1'b0;
        rst     = 1'b0;
    endtask

    task automatic test_reset();
        step(OP_NOP, '0, 1'b0, 1'b1);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if ({ovf, udf} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {ovf, udf}); end
        checks++; if (data_raw !== 64'h0) begin errors++; $display("FAIL reset_raw got %h exp 0", data_raw); end
    endtask

    task automatic test_push();
        step(OP_PUSH, 16'h1111, 1'b0, 1'b0);
        checks++; if (data_out !== 16'h1111) begin errors++; $display("FAIL push1_top got %h exp 1111", data_out); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL push1_count got %0d exp 1", count); end
        step(OP_PUSH, 16'h2222, 1'b0, 1'b0);
        checks++; if (data_out !== 16'h2222) begin errors++; $display("FAIL push2_top got %h exp 2222", data_out); end
        checks++; if (data_next !== 16'h1111) begin errors++; $display("FAIL push2_next got %h exp 1111", data_next); end
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL push2_count got %0d exp 2", count); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL push2_empty got %b exp 0", empty); end
        checks++; if ({ovf, udf} !== 2'b00) begin errors++; $display("FAIL push2_flags got %b exp 00", {ovf, udf}); end
    endtask

    task automatic test_pop_load();
        step(OP_CLEAR, '0, 1'b0, 1'b0);
        step(OP_PUSH, 16'h0004, 1'b0, 1'b0);
        step(OP_PUSH, 16'h0003, 1'b0, 1'b0);
        step(OP_POP_LOAD, 16'h0007, 1'b0, 1'b0);
        checks++; if (data_out !== 16'h0007) begin errors++; $display("FAIL popload_top got %h exp 0007", data_out); end
        checks++; if (data_next !== 16'h0000) begin errors++; $display("FAIL popload_next got %h exp 0000", data_next); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL popload_count got %0d exp 1", count); end
        checks++; if (udf !== 1'b0) begin errors++; $display("FAIL popload_udf got %b exp 0", udf); end
        step(OP_POP_LOAD, 16'h0009, 1'b0, 1'b0);
        checks++; if (udf !== 1'b1) begin errors++; $display("FAIL popload2_udf got %b exp 1", udf); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL popload2_count got %0d exp 0", count); end
        checks++; if (data_out !== 16'h0009) begin errors++; $display("FAIL popload2_top got %h exp 0009", data_out); end
    endtask

    task automatic test_overflow();
        step(OP_CLEAR, '0, 1'b0, 1'b0);
        checks++; if (udf !== 1'b0) begin errors++; $display("FAIL clear_udf got %b exp 0", udf); end
        for (int i = 1; i <= 4; i++) step(OP_PUSH, 16'(i), 1'b0, 1'b0);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", full); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_pre got %b exp 0", ovf); end
        step(OP_PUSH, 16'h0005, 1'b0, 1'b0);
        checks++; if (data_raw !== 64'h0002_0003_0004_0005) begin errors++; $display("FAIL ovf_raw got %h exp 0002000300040005", data_raw); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d exp 4", count); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", ovf); end
        step(OP_NOP, '0, 1'b1, 1'b0);
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_errclr got %b exp 0", ovf); end
        // err_clr together with a fresh overflow: the new error must stick.
        step(OP_DUP, '0, 1'b1, 1'b0);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_clr_vs_new got %b exp 1", ovf); end
        checks++; if (data_raw !== 64'h0003_0004_0005_0005) begin errors++; $display("FAIL ovf_dup_raw got %h exp 0003000400050005", data_raw); end
    endtask

    task automatic test_dup_swap();
        step(OP_CLEAR, '0, 1'b0, 1'b0);
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL clear_ovf got %b exp 0", ovf); end
        step(OP_PUSH, 16'h000B, 1'b0, 1'b0);
        step(OP_PUSH, 16'h000A, 1'b0, 1'b0);
        step(OP_DUP, '0, 1'b0, 1'b0);
        checks++; if (data_raw !== 64'h0000_000B_000A_000A) begin errors++; $display("FAIL dup_raw got %h exp 0000000B000A000A", data_raw); end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL dup_count got %0d exp 3", count); end
        step(OP_SWAP, '0, 1'b0, 1'b0);
        checks++; if (data_raw !== 64'h0000_000B_000A_000A) begin errors++; $display("FAIL swap1_raw got %h exp 0000000B000A000A", data_raw); end
        checks++; if (udf !== 1'b0) begin errors++; $display("FAIL swap1_udf got %b exp 0", udf); end
        step(OP_POP, '0, 1'b0, 1'b0);
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL pop_count got %0d exp 2", count); end
        step(OP_SWAP, '0, 1'b0, 1'b0);
        checks++; if (data_out !== 16'h000B) begin errors++; $display("FAIL swap2_top got %h exp 000B", data_out); end
        checks++; if (data_next !== 16'h000A) begin errors++; $display("FAIL swap2_next got %h exp 000A", data_next); end
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL swap2_count got %0d exp 2", count); end
    endtask

    task automatic test_underflow_peek();
        step(OP_CLEAR, '0, 1'b0, 1'b0);
        step(OP_POP, '0, 1'b0, 1'b0);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL udf_count got %0d exp 0", count); end
        checks++; if (udf !== 1'b1) begin errors++; $display("FAIL udf_flag got %b exp 1", udf); end
        checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL udf_top got %h exp 0000", data_out); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL udf_empty got %b exp 1", empty); end
        step(OP_NOP, '0, 1'b0, 1'b0);
        checks++; if (udf !== 1'b1) begin errors++; $display("FAIL udf_sticky got %b exp 1", udf); end
        step(OP_CLEAR, '0, 1'b0, 1'b0);
        step(OP_LOAD, 16'h0005, 1'b0, 1'b0);
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL load_empty_count got %0d exp 1", count); end
        checks++; if (data_out !== 16'h0005) begin errors++; $display("FAIL load_top got %h exp 0005", data_out); end
        step(OP_LOAD, 16'h0006, 1'b0, 1'b0);
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL load_keep_count got %0d exp 1", count); end
        step(OP_SWAP, '0, 1'b0, 1'b0);
        checks++; if (udf !== 1'b1) begin errors++; $display("FAIL swap_udf got %b exp 1", udf); end
        checks++; if (data_next !== 16'h0006) begin errors++; $display("FAIL swap_udf_next got %h exp 0006", data_next); end
        step(OP_CLEAR, '0, 1'b0, 1'b0);
        step(OP_PUSH, 16'h0009, 1'b0, 1'b0);
        step(OP_PUSH, 16'h0008, 1'b0, 1'b0);
        step(OP_PUSH, 16'h0007, 1'b0, 1'b0);
        peek_idx = 2'd2;
        #1;
        checks++; if (peek_data !== 16'h0009) begin errors++; $display("FAIL peek2 got %h exp 0009", peek_data); end
        peek_idx = 2'd0;
        #1;
        checks++; if (peek_data !== 16'h0007) begin errors++; $display("FAIL peek0 got %h exp 0007", peek_data); end
        peek_idx = 2'(DEPTH - 1);
        #1;
        checks++; if (peek_data !== 16'h0000) begin errors++; $display("FAIL peek_last got %h exp 0000", peek_data); end
        peek_idx = '0;
    endtask

    task automatic test_reset_mid();
        step(OP_CLEAR, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(OP_PUSH, 16'h00A0 + 16'(i), 1'b0, 1'b0);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL rstmid_pre_ovf got %b exp 1", ovf); end
        step(OP_PUSH, 16'hFFFF, 1'b0, 1'b1);
        checks++; if (data_raw !== 64'h0) begin errors++; $display("FAIL rstmid_raw got %h exp 0", data_raw); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", count); end
        checks++; if ({ovf, udf} !== 2'b00) begin errors++; $display("FAIL rstmid_flags got %b exp 00", {ovf, udf}); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty got %b exp 1", empty); end
    endtask

    initial begin
        rst      = 1'b1;
        op       = OP_NOP;
        data_in  = '0;
        err_clr  = 1'b0;
        peek_idx = '0;
        test_reset();
        test_push();
        test_pop_load();
        test_overflow();
        test_dup_swap();
        test_underflow_peek();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/op_stack.md
Name: op_stack

Overview:
- Parametrised successor to the CPU's shift-register operand stack.
- Adds an encoded command port that supersedes the separate pop/push/load strobes, with DUP/SWAP/CLEAR/POP_LOAD commands.
- Tracks occupancy (count, full/empty) and raises sticky overflow/underflow error flags.
- Provides a combinational indexed peek port; sits between the instruction decoder/ALU and the datapath.

Parameters:
- WIDTH, 16, bits per stack entry
- DEPTH, 16, number of entries (>= 2)
- CW, $clog2(DEPTH+1), width of count output
- IW, $clog2(DEPTH), width of peek index

Ports:
- clk  input  1  clock; all state changes on posedge
- rst  input  1  synchronous active-high reset
- op  input  3  command, stack_op_t from stack_pkg
- data_in  input  WIDTH  operand for PUSH/LOAD/POP_LOAD
- err_clr  input  1  clears sticky error flags
- data_out  output  WIDTH  top of stack, entry 0
- data_next  output  WIDTH  entry 1
- peek_idx  input  IW  index for peek_data
- peek_data  output  WIDTH  entry[peek_idx], combinational
- count  output  CW  valid entries, 0..DEPTH
- empty  output  1  count==0
- full  output  1  count==DEPTH
- ovf  output  1  sticky overflow
- udf  output  1  sticky underflow
- data_raw  output  WIDTH*DEPTH  flattened debug view, entry i at bits [i*WIDTH +: WIDTH]

Behaviour:
- Reset is synchronous: rst high at posedge clears all entries, count, ovf and udf to 0. rst overrides op and err_clr. Reset mid-sequence discards in-flight contents.
- Storage is a shift array: entry 0 is top. All outputs except peek_data are registered or decoded from registers. Latency is 1 cycle from op to visible result.
- Commands (d = data_in, e[i] = entry i):
  - NOP (0): hold.
  - LOAD (1): e0 <= d; count unchanged. If count==0, count becomes 1; no error.
  - PUSH (2): e[i] <= e[i-1] for i>=1; e0 <= d; count+1.
  - POP (3): e[i] <= e[i+1]; e[DEPTH-1] <= 0; count-1.
  - POP_LOAD (4): binary-op result write. e0 <= d; e[i] <= e[i+1] for i>=1; e[DEPTH-1] <= 0; count-1.
  - DUP (5): like PUSH with e0 <= e0; count+1.
  - SWAP (6): e0 <= e1, e1 <= e0; count unchanged.
  - CLEAR (7): all entries <= 0; count <= 0; ovf, udf <= 0.
- Overflow: PUSH/DUP with count==DEPTH.
  - Shift is still performed; the bottom entry is lost.
  - count stays at DEPTH; ovf <= 1.
- Underflow: POP with count==0, POP_LOAD with count<2, or SWAP with count<2.
  - Data movement is still performed.
  - count saturates at 0 (POP_LOAD at count==1 goes to 1 − 1 = 0 without error only if count>=2; at count==1 count becomes 0 and udf <= 1).
  - udf <= 1.
- Sticky flags hold until err_clr, CLEAR or rst. If err_clr coincides with a new error, the new error wins (flag ends 1).
- The count arithmetic is CW-bit with explicit saturation; it never wraps.
- peek_data = e[peek_idx] when peek_idx < DEPTH, else 0.
- empty and full decode from count; both are registered-equivalent, with no combinational path from op.

Decomposition:
- stack_pkg: typedef enum logic [2:0] stack_op_t {OP_NOP, OP_LOAD, OP_PUSH, OP_POP, OP_POP_LOAD, OP_DUP, OP_SWAP, OP_CLEAR}.
- stack_pkg is shared with the decoder.
- No sub-module: a single always_ff for entries plus count/flag logic. The peek mux is a continuous assign.

Test Plan:
- Reset/push: rst, then PUSH 0x1111, PUSH 0x2222 -> data_out=0x2222, data_next=0x1111, count=2, empty=0, ovf=udf=0.
- ALU pattern: stack [0x0003, 0x0004], POP_LOAD d=0x0007 -> data_out=0x0007, count=1, e1=0; then POP_LOAD again -> udf=1, count=0.
- Overflow: DEPTH=4, PUSH 1,2,3,4 -> full=1; PUSH 5 -> data_raw entries {5,4,3,2}, count=4, ovf=1; err_clr -> ovf=0.
- DUP/SWAP: stack [0xA,0xB], DUP -> [0xA,0xA,0xB] count=3; SWAP -> [0xA,0xA,0xB]; POP, SWAP -> [0xB,0xA].
- Underflow/peek: empty stack POP -> count=0, udf=1, data_out=0; peek_idx=2 on [7,8,9] -> peek_data=9; peek_idx=DEPTH-1 on 3-entry stack -> 0.
- Sync reset mid-op: rst asserted together with PUSH 0xFFFF -> next cycle all entries 0, count=0, flags 0; rst with err_clr=0 and ovf set -> ovf=0.
